// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing FSM with a tick prescaler driving an external counter chain.
// Optional lap-freeze feature compiled in with macro STOPWATCH_LAP_EN.
`timescale 1ns/1ps

// state | meaning
// IDLE  | counters held at initial value, prescaler cleared
// RUN   | prescaler counting, ticks advance the counter chain
// PAUSE | prescaler and counters frozen, partial second kept
// LAP   | as RUN, but display latch frozen
// DONE  | counter chain reached its limit, waiting for clear
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    input  logic       at_max,
    output logic       cnt_increase,
    output logic       cnt_rst_state,
    output logic       disp_hold,
    output logic       running,
    output logic [2:0] state
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_PAUSE = 3'd2;
    localparam logic [2:0] ST_LAP   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [26:0] PRESC_LAST = 27'(TICK_DIV - 1);

    logic [2:0]  state_r;
    logic [2:0]  state_d;
    logic [26:0] presc_r;
    logic [26:0] presc_d;
    logic        active;
    logic        tick;
    logic        lap_evt;

`ifdef STOPWATCH_LAP_EN
    assign lap_evt   = btn_lap;
    assign disp_hold = (state_r == ST_LAP);
`else
    logic lap_unused;
    assign lap_unused = btn_lap;
    assign lap_evt    = 1'b0;
    assign disp_hold  = 1'b0;
`endif

    assign active        = (state_r == ST_RUN) || (state_r == ST_LAP);
    assign tick          = active && (presc_r == PRESC_LAST);
    assign cnt_increase  = tick && !at_max;
    assign cnt_rst_state = (state_r == ST_IDLE);
    assign running       = active;
    assign state         = state_r;

    // Prescaler keeps its partial count through PAUSE/DONE so a resume is seamless.
    always_comb begin
        presc_d = presc_r;
        if (active) begin
            if (tick) begin
                presc_d = '0;
            end else begin
                presc_d = presc_r + 27'd1;
            end
        end else if (state_r == ST_PAUSE || state_r == ST_DONE) begin
            presc_d = presc_r;
        end else begin
            presc_d = '0;
        end
    end

    always_comb begin
        state_d = state_r;
        case (state_r)
            ST_IDLE: begin
                if (btn_start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (btn_start)             state_d = ST_PAUSE;
                else if (lap_evt)          state_d = ST_LAP;
                else if (tick && at_max)   state_d = ST_DONE;
            end
`ifdef STOPWATCH_LAP_EN
            ST_LAP: begin
                if (btn_start)             state_d = ST_PAUSE;
                else if (lap_evt)          state_d = ST_RUN;
                else if (tick && at_max)   state_d = ST_DONE;
            end
`endif
            ST_PAUSE: begin
                if (btn_start)             state_d = ST_RUN;
                else if (btn_clear)        state_d = ST_IDLE;
            end
            ST_DONE: begin
                if (btn_clear)             state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            presc_r <= '0;
        end else begin
            state_r <= state_d;
            presc_r <= presc_d;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with TICK_DIV=4: driver queues per-cycle expectations,
// monitor pops and compares them at the falling edge (or on demand for the async reset check).
`timescale 1ns/1ps

module tb_stopwatch_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_start;
    logic       btn_clear;
    logic       btn_lap;
    logic       at_max;
    logic       cnt_increase;
    logic       cnt_rst_state;
    logic       disp_hold;
    logic       running;
    logic [2:0] state;

    typedef struct {
        logic [2:0] st;
        logic       inc;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;
    int   checks = 0;
    int   passed = 0;

    stopwatch_ctrl #(.TICK_DIV(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_start    (btn_start),
        .btn_clear    (btn_clear),
        .btn_lap      (btn_lap),
        .at_max       (at_max),
        .cnt_increase (cnt_increase),
        .cnt_rst_state(cnt_rst_state),
        .disp_hold    (disp_hold),
        .running      (running),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares every observable output against the queued expectation.
    initial begin
        forever begin
            @(negedge clk or sample_ev);
            #0;
            if (exp_q.size() > 0) begin
                exp_t e;
                logic e_rst, e_hold, e_run;
                e = exp_q.pop_front();
                e_rst  = (e.st == 3'd0);
                e_hold = (e.st == 3'd3);
                e_run  = (e.st == 3'd1) || (e.st == 3'd3);
                checks++;
                if (state === e.st && cnt_increase === e.inc && cnt_rst_state === e_rst &&
                    disp_hold === e_hold && running === e_run) begin
                    passed++;
                end else begin
                    $display("FAIL %s: got state=%0d inc=%b rst=%b hold=%b run=%b, expected state=%0d inc=%b rst=%b hold=%b run=%b",
                             e.name, state, cnt_increase, cnt_rst_state, disp_hold, running,
                             e.st, e.inc, e_rst, e_hold, e_run);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    task automatic push_exp(input logic [2:0] st, input logic inc, input string name);
        exp_t e;
        e.st   = st;
        e.inc  = inc;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input logic s, input logic c, input logic l, input logic m,
                        input logic [2:0] est, input logic einc, input string name);
        btn_start = s;
        btn_clear = c;
        btn_lap   = l;
        at_max    = m;
        push_exp(est, einc, name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_start = 1'b0;
        btn_clear = 1'b0;
        btn_lap   = 1'b0;
        at_max    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        step(0, 0, 0, 1, 3'd0, 0, "reset_hold");
        rst_n = 1'b1;
        step(0, 0, 0, 0, 3'd0, 0, "idle");

        // Counting: one pulse every 4 clocks, 3 pulses in 12
        step(1, 0, 0, 0, 3'd0, 0, "idle_start");
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 3'd1, (i % 4 == 3), "run_cnt");

        // Pause after 2 prescaler counts, resume keeps the partial count
        step(0, 0, 0, 0, 3'd1, 0, "run_p0");
        step(1, 0, 0, 0, 3'd1, 0, "pause_req");
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 3'd2, 0, "paused");
        step(1, 0, 0, 0, 3'd2, 0, "resume");
        step(0, 0, 0, 0, 3'd1, 0, "resume_p2");
        step(0, 0, 0, 0, 3'd1, 1, "resume_tick");

        // Tick coinciding with start still pulses; pause follows
        step(0, 0, 0, 0, 3'd1, 0, "run_p0b");
        step(0, 0, 0, 0, 3'd1, 0, "run_p1b");
        step(0, 0, 0, 0, 3'd1, 0, "run_p2b");
        step(1, 0, 0, 0, 3'd1, 1, "tick_start");
        step(0, 0, 0, 0, 3'd2, 0, "paused2");
        step(0, 1, 0, 0, 3'd2, 0, "pause_clear");
        step(0, 0, 0, 0, 3'd0, 0, "idle2");

        // Coincidence: start beats lap; clear ignored in RUN
        step(1, 0, 0, 0, 3'd0, 0, "idle_start2");
        step(0, 1, 0, 0, 3'd1, 0, "run_clear_ign");
        step(0, 0, 0, 0, 3'd1, 0, "run_after_clear");
        step(1, 0, 1, 0, 3'd1, 0, "start_lap");
        step(0, 0, 0, 0, 3'd2, 0, "pause_after_coinc");
        step(1, 0, 0, 0, 3'd2, 0, "resume2");
        step(0, 0, 0, 0, 3'd1, 1, "resume_p3_tick");

`ifdef STOPWATCH_LAP_EN
        step(0, 0, 1, 0, 3'd1, 0, "lap_req");
        step(0, 0, 0, 0, 3'd3, 0, "lap_p1");
        step(0, 0, 0, 0, 3'd3, 0, "lap_p2");
        step(0, 0, 0, 0, 3'd3, 1, "lap_tick");
        step(0, 0, 1, 0, 3'd3, 0, "lap_exit");
        step(0, 0, 0, 0, 3'd1, 0, "run_after_lap");
`else
        step(0, 0, 1, 0, 3'd1, 0, "lap_ign");
        step(0, 0, 0, 0, 3'd1, 0, "run_after_lap_ign");
`endif

        // Max reached: no pulse on the tick, DONE, start ignored, clear returns to IDLE
        step(0, 0, 0, 1, 3'd1, 0, "max_p2");
        step(0, 0, 0, 1, 3'd1, 0, "max_tick_noinc");
        step(1, 0, 0, 1, 3'd4, 0, "done_start_ign");
        step(0, 0, 0, 1, 3'd4, 0, "done_hold");
        step(0, 1, 0, 0, 3'd4, 0, "done_clear");
        step(0, 0, 0, 0, 3'd0, 0, "idle3");

        // Asynchronous reset mid-RUN, observed with no clock edge in between
        step(1, 0, 0, 0, 3'd0, 0, "idle_start3");
        step(0, 0, 0, 0, 3'd1, 0, "run_before_rst");
        #1;
        rst_n = 1'b0;
        #1;
        push_exp(3'd0, 0, "async_reset");
        ->sample_ev;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 3'd0, 0, "reset_held");
        rst_n = 1'b1;
        step(0, 0, 0, 0, 3'd0, 0, "post_reset_idle");
        step(1, 0, 0, 0, 3'd0, 0, "restart");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 3'd1, (i == 3), "restart_cnt");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter: TICK_DIV, 100000000, clk cycles per count tick (1 Hz at 100 MHz); legal range 2..2^27.
REQ-002 SHALL have ports:
- clk  input  1  global clock
- rst_n  input  1  asynchronous active-low reset
- btn_start  input  1  debounced one-cycle pulse: start/pause toggle
- btn_clear  input  1  debounced one-cycle pulse: clear to initial value
- btn_lap  input  1  debounced one-cycle pulse: lap freeze toggle
- at_max  input  1  high when every counter in the external chain equals its limit
- cnt_increase  output  1  increase enable to least-significant counter
- cnt_rst_state  output  1  load-initial-value command to all counters
- disp_hold  output  1  display latch freeze
- running  output  1  high in RUN or LAP
- state  output  3  current state code
REQ-003 SHALL use one clock, clk; reset is asynchronous and active-low on rst_n.

Function
REQ-004 SHALL implement states IDLE=3'd0, RUN=3'd1, PAUSE=3'd2, LAP=3'd3, DONE=3'd4; codes 5-7 SHALL return to IDLE next cycle.
REQ-005 SHALL contain a 27-bit prescaler:
- counts 0..TICK_DIV-1 in RUN/LAP
- holds its value in PAUSE/DONE so resume keeps the partial second
- clears to 0 in IDLE
REQ-006 SHALL assert internal tick for exactly one cycle when prescaler==TICK_DIV-1 in RUN/LAP; prescaler wraps to 0 on that cycle.
REQ-007 SHALL drive cnt_increase combinationally = tick AND (RUN or LAP) AND NOT at_max.
REQ-008 SHALL drive cnt_rst_state = 1 iff state==IDLE; disp_hold = 1 iff state==LAP; running = 1 iff RUN or LAP.
REQ-009 SHALL take these transitions (evaluated at the clock edge):
- IDLE: btn_start -> RUN
- RUN: btn_start -> PAUSE; else btn_lap -> LAP; else tick AND at_max -> DONE
- LAP: btn_start -> PAUSE; else btn_lap -> RUN; else tick AND at_max -> DONE
- PAUSE: btn_start -> RUN; else btn_clear -> IDLE
- DONE: btn_clear -> IDLE; btn_start ignored
REQ-010 SHALL give priority start > lap > clear > max-reached when events coincide.
REQ-011 SHALL ignore btn_clear in RUN and LAP.
REQ-012 SHALL still emit the cnt_increase pulse when a tick coincides with btn_start in RUN/LAP; the pause takes effect the following cycle.
REQ-013 SHALL never assert cnt_increase while at_max=1, so the counter chain never wraps.
REQ-014 SHALL leave PAUSE→RUN pauses exactly at the prescaler value held on entry.

Reset
REQ-015 SHALL, on rst_n low, immediately force state=IDLE and prescaler=0, independent of clk.
REQ-016 SHALL, during and after reset, output cnt_rst_state=1, cnt_increase=0, disp_hold=0, running=0, state=3'd0.
REQ-017 SHALL abandon any state on reset mid-operation, including LAP and DONE; no state is retained.

Configuration
REQ-018 SHALL compile the lap feature only when macro STOPWATCH_LAP_EN is defined.
REQ-019 SHALL, with STOPWATCH_LAP_EN undefined:
- ignore btn_lap
- make LAP unreachable
- tie disp_hold to 0
- leave all other behaviour unchanged

Verification (TICK_DIV=4)
REQ-020 SHALL verify reset: rst_n low mid-RUN -> state=0 and cnt_rst_state=1 with no clk edge; cnt_increase=0.
REQ-021 SHALL verify counting: btn_start in IDLE -> state=1; cnt_increase pulses 1 cycle every 4 clk; 12 clk -> 3 pulses.
REQ-022 SHALL verify pause: pause after 2 prescaler counts, wait 10 clk with no pulses, resume -> first pulse exactly 2 clk after resume.
REQ-023 SHALL verify max reached: at_max=1 in RUN -> next tick gives no cnt_increase and state=4; btn_start ignored; btn_clear -> state=0.
REQ-024 SHALL verify lap (macro defined): btn_lap in RUN -> state=3, disp_hold=1, pulses continue; btn_lap -> state=1, disp_hold=0. Undefined: btn_lap -> state stays 1.
REQ-025 SHALL verify coincidence: btn_start and btn_lap in the same RUN cycle -> state=2; btn_clear in RUN -> state stays 1.
